// File: rtl/farm_pkg.sv
// Shared defaults and helpers for the sensor window monitor.
// Threshold select encodings and a width helper.
package farm_pkg;

  localparam int DEF_DW       = 8;
  localparam int DEF_NCH      = 4;
  localparam int DEF_AVG_LOG2 = 2;

  localparam logic CFG_MIN = 1'b0;
  localparam logic CFG_MAX = 1'b1;

  // Bits needed to index n items, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/alert_debounce.sv
// Per-channel alert debounce: counts consecutive qualifying
// averages and toggles the alert after DEB of them.
// Ports: clk, rst_n, eval, out, in_band -> alert, cnt.
module alert_debounce
  import farm_pkg::*;
#(
  parameter int DEB = 3,
  localparam int CNTW = clog2(DEB + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            eval,
  input  logic            out,
  input  logic            in_band,
  output logic            alert,
  output logic [CNTW-1:0] cnt
);

  logic            alert_d;
  logic [CNTW-1:0] cnt_d;
  logic            qual;

  // While clear, out-of-window averages qualify to set;
  // while set, in-band averages qualify to clear.
  always_comb begin
    alert_d = alert;
    cnt_d   = cnt;
    qual    = alert ? in_band : out;
    if (eval) begin
      if (!qual) begin
        cnt_d = '0;
      end else if (cnt == CNTW'(DEB - 1)) begin
        alert_d = ~alert;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alert <= 1'b0;
      cnt   <= '0;
    end else begin
      alert <= alert_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_window_monitor.sv
// Per-channel moving average with debounced min/max alerts.
// Ports: sample in (s_*), config (cfg_*), avg_* out, alerts, drop_err.
module sensor_window_monitor
  import farm_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DW       = DEF_DW,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int DEB      = 3,
  parameter int HYST     = 4,
  localparam int CW = clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          s_valid,
  input  logic [CW-1:0] s_chan,
  input  logic [DW-1:0] s_data,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_chan,
  input  logic          cfg_sel,
  input  logic [DW-1:0] cfg_data,
  output logic          avg_valid,
  output logic [CW-1:0] avg_chan,
  output logic [DW-1:0] avg_data,
  output logic          avg_primed,
  output logic [NCH-1:0] alert_vec,
  output logic          alert_any,
  output logic          drop_err
);

  localparam int D    = 1 << AVG_LOG2;
  localparam int SW   = DW + AVG_LOG2;
  localparam int PW   = AVG_LOG2;
  localparam int CNTW = clog2(DEB + 1);

  logic [DW-1:0]  ring_q [NCH][D];
  logic [SW-1:0]  sum_q  [NCH];
  logic [PW-1:0]  ptr_q  [NCH];
  logic [NCH-1:0] primed_q;
  logic [DW-1:0]  min_q  [NCH];
  logic [DW-1:0]  max_q  [NCH];

  // Stage 1 read-modify-write of the selected channel.
  logic          in_range;
  logic          accept;
  logic          drop;
  logic [CW-1:0] c;
  logic [DW-1:0] old;
  logic [SW-1:0] new_sum;
  logic          wrap;

  always_comb begin
    in_range = 32'(s_chan) < NCH;
    accept   = ena & s_valid & in_range;
    drop     = ena & s_valid & ~in_range;
    c        = in_range ? s_chan : '0;
    old      = ring_q[c][ptr_q[c]];
    new_sum  = sum_q[c] - SW'(old) + SW'(s_data);
    wrap     = ptr_q[c] == PW'(D - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < D; j++) begin
          ring_q[i][j] <= '0;
        end
        sum_q[i] <= '0;
        ptr_q[i] <= '0;
      end
      primed_q   <= '0;
      avg_valid  <= 1'b0;
      avg_chan   <= '0;
      avg_data   <= '0;
      avg_primed <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      avg_valid <= accept;
      if (accept) begin
        ring_q[c][ptr_q[c]] <= s_data;
        sum_q[c]   <= new_sum;
        ptr_q[c]   <= ptr_q[c] + 1'b1;
        if (wrap) primed_q[c] <= 1'b1;
        avg_chan   <= c;
        avg_data   <= new_sum[SW-1:AVG_LOG2];
        avg_primed <= primed_q[c] | wrap;
      end
      if (drop) drop_err <= 1'b1;
    end
  end

  // Threshold registers; reset leaves the window wide open.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        min_q[i] <= '0;
        max_q[i] <= '1;
      end
    end else if (cfg_we && 32'(cfg_chan) < NCH) begin
      if (cfg_sel == CFG_MIN) min_q[cfg_chan] <= cfg_data;
      else                    max_q[cfg_chan] <= cfg_data;
    end
  end

  // Stage 2 window and hysteresis band compare.
  logic [DW-1:0] mn;
  logic [DW-1:0] mx;
  logic [DW:0]   av;
  logic [DW:0]   lo;
  logic [DW:0]   hi;
  logic          out_rng;
  logic          in_band;
  logic          hi_ok;

  always_comb begin
    mn      = min_q[avg_chan];
    mx      = max_q[avg_chan];
    av      = {1'b0, avg_data};
    lo      = {1'b0, mn} + (DW + 1)'(HYST);
    hi      = {1'b0, mx} - (DW + 1)'(HYST);
    // Guard against max-HYST wrapping below zero.
    hi_ok   = {1'b0, mx} >= (DW + 1)'(HYST);
    out_rng = (avg_data < mn) || (avg_data > mx);
    in_band = hi_ok && (av >= lo) && (av <= hi);
  end

  logic [NCH*CNTW-1:0] cnt_flat;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic eval;
    assign eval = avg_valid & avg_primed
                & (32'(avg_chan) == i);
    alert_debounce #(
      .DEB(DEB)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .eval   (eval),
      .out    (out_rng),
      .in_band(in_band),
      .alert  (alert_vec[i]),
      .cnt    (cnt_flat[i*CNTW +: CNTW])
    );
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt_flat;

  always_ff @(posedge clk) begin
    if (!rst_n) alert_any <= 1'b0;
    else        alert_any <= |alert_vec;
  end

endmodule

// File: tb/tb_sensor_window_monitor.sv
// Directed bench for sensor_window_monitor.
// Two instances: NCH=4 for main flow, NCH=3 for drop handling.
module tb_sensor_window_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       ena3;
  logic       s_valid;
  logic [1:0] s_chan;
  logic [7:0] s_data;
  logic       cfg_we;
  logic [1:0] cfg_chan;
  logic       cfg_sel;
  logic [7:0] cfg_data;

  logic       av4, ap4, any4, de4;
  logic [1:0] ac4;
  logic [7:0] ad4;
  logic [3:0] al4;

  logic       av3, ap3, any3, de3;
  logic [1:0] ac3;
  logic [7:0] ad3;
  logic [2:0] al3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensor_window_monitor #(.NCH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .avg_valid(av4), .avg_chan(ac4), .avg_data(ad4),
    .avg_primed(ap4), .alert_vec(al4),
    .alert_any(any4), .drop_err(de4)
  );

  sensor_window_monitor #(.NCH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena3),
    .s_valid(s_valid), .s_chan(s_chan), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .avg_valid(av3), .avg_chan(ac3), .avg_data(ad3),
    .avg_primed(ap3), .alert_vec(al3),
    .alert_any(any3), .drop_err(de3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch,
                      input logic [7:0] d);
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic sendc(input string tag,
                       input logic [1:0] ch,
                       input logic [7:0] d,
                       input int ea,
                       input logic ep);
    send(ch, d);
    chk({tag, "_valid"}, 32'(av4), 1);
    chk({tag, "_chan"}, 32'(ac4), 32'(ch));
    chk({tag, "_data"}, 32'(ad4), ea);
    chk({tag, "_primed"}, 32'(ap4), 32'(ep));
  endtask

  task automatic cfg(input logic [1:0] ch,
                     input logic sel,
                     input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_chan = ch;
    cfg_sel  = sel;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  int e2 [6] = '{50, 100, 150, 200, 200, 200};
  int e3 [6] = '{187, 175, 162, 150, 150, 150};
  int e3s[4] = '{162, 175, 187, 200};
  int e3h[8] = '{189, 179, 168, 158, 158, 158, 158, 158};
  int e6 [6] = '{63, 127, 191, 255, 255, 255};

  initial begin
    rst_n = 1'b0; ena = 1'b1; ena3 = 1'b0;
    s_valid = 1'b0; s_chan = '0; s_data = '0;
    cfg_we = 1'b0; cfg_chan = '0; cfg_sel = 1'b0;
    cfg_data = '0;
    repeat (3) tick();
    chk("rst_avg_valid", 32'(av4), 0);
    chk("rst_avg_data", 32'(ad4), 0);
    chk("rst_alert_vec", 32'(al4), 0);
    chk("rst_alert_any", 32'(any4), 0);
    chk("rst_drop_err", 32'(de4), 0);
    rst_n = 1'b1;
    tick();

    // Priming on ch0 with zero-filled history.
    sendc("t1a", 2'd0, 8'd100, 25, 1'b0);
    sendc("t1b", 2'd0, 8'd100, 50, 1'b0);
    sendc("t1c", 2'd0, 8'd100, 75, 1'b0);
    sendc("t1d", 2'd0, 8'd100, 100, 1'b1);
    tick(); tick();
    chk("t1_alert_vec", 32'(al4), 0);

    // Out-of-window alert set on ch1.
    cfg(2'd1, 1'b0, 8'd100);
    cfg(2'd1, 1'b1, 8'd160);
    for (int i = 0; i < 6; i++)
      sendc("t2", 2'd1, 8'd200, e2[i], i >= 3);
    chk("t2_alert_t1", 32'(al4), 0);
    tick();
    chk("t2_alert_t2", 32'(al4), 2);
    chk("t2_any_t2", 32'(any4), 0);
    tick();
    chk("t2_any_t3", 32'(any4), 1);

    // Clear through the hysteresis band.
    for (int i = 0; i < 6; i++)
      sendc("t3", 2'd1, 8'd150, e3[i], 1'b1);
    chk("t3_alert_t1", 32'(al4), 2);
    tick();
    chk("t3_alert_t2", 32'(al4), 0);
    tick();
    chk("t3_any_t3", 32'(any4), 0);

    // Re-set, then hold inside window above the band.
    for (int i = 0; i < 4; i++)
      sendc("t3s", 2'd1, 8'd200, e3s[i], 1'b1);
    tick(); tick();
    chk("t3s_alert", 32'(al4), 2);
    for (int i = 0; i < 8; i++)
      sendc("t3h", 2'd1, 8'd158, e3h[i], 1'b1);
    tick(); tick();
    chk("t3h_alert_hold", 32'(al4), 2);

    // Interleaved channels, then back-to-back on ch2.
    for (int r = 0; r < 4; r++) begin
      sendc("t4c0", 2'd0, 8'd60, 90 - 10 * r, 1'b1);
      sendc("t4c1", 2'd1, 8'd158, 158, 1'b1);
      sendc("t4c2", 2'd2, 8'd0, 0, r == 3);
      sendc("t4c3", 2'd3, 8'd20, 5 * (r + 1), r == 3);
    end
    sendc("t4b2a", 2'd2, 8'd40, 10, 1'b1);
    sendc("t4b2b", 2'd2, 8'd80, 30, 1'b1);
    tick(); tick();
    chk("t4_alert_vec", 32'(al4), 2);

    // Out-of-range channel on NCH=3; ena low on NCH=4.
    ena = 1'b0; ena3 = 1'b1;
    send(2'd3, 8'd77);
    chk("t5_drop_valid", 32'(av3), 0);
    chk("t5_drop_err", 32'(de3), 1);
    chk("t5_ena_low_valid", 32'(av4), 0);
    chk("t5_ena_low_drop", 32'(de4), 0);
    send(2'd0, 8'd40);
    chk("t5_c0_valid", 32'(av3), 1);
    chk("t5_c0_chan", 32'(ac3), 0);
    chk("t5_c0_data", 32'(ad3), 10);
    chk("t5_c0_primed", 32'(ap3), 0);
    chk("t5_ena_low_valid2", 32'(av4), 0);
    ena3 = 1'b0; ena = 1'b1;
    tick();
    chk("t5_drop_sticky", 32'(de3), 1);

    // Reset with an out-of-range sample in flight.
    cfg(2'd0, 1'b1, 8'd50);
    send(2'd0, 8'd255);
    chk("t6_pre_valid", 32'(av4), 1);
    chk("t6_pre_data", 32'(ad4), 108);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 32'(av4), 0);
    chk("t6_rst_alert", 32'(al4), 0);
    chk("t6_rst_drop3", 32'(de3), 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_post_valid", 32'(av4), 0);
    chk("t6_post_alert", 32'(al4), 0);
    chk("t6_post_any", 32'(any4), 0);
    for (int i = 0; i < 6; i++)
      sendc("t6c0", 2'd0, 8'd255, e6[i], i >= 3);
    tick(); tick();
    chk("t6_max_restored", 32'(al4), 0);
    for (int i = 0; i < 6; i++)
      sendc("t6c1", 2'd1, 8'd0, 0, i >= 3);
    tick(); tick();
    chk("t6_min_restored", 32'(al4), 0);
    chk("t6_any_final", 32'(any4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_window_monitor.md
Name: sensor_window_monitor

Overview:
Parametrised next-generation environmental monitor for the microgreen controller. Accepts time-multiplexed sensor samples tagged with a channel number. Keeps a per-channel moving average, programmable min/max alert window, debounce and hysteresis. Sits between the sensor front-end mux and the alert/buzzer and status logic; replaces fixed 4-channel, fixed-threshold sensor handling.

Parameters:
NCH, 4, number of sensor channels (2..16)
DW, 8, sample width
AVG_LOG2, 2, averaging depth D = 2^AVG_LOG2 (1..4)
DEB, 3, consecutive qualifying averages needed to set or clear an alert (1..15)
HYST, 4, hysteresis margin in LSBs applied on alert clear

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  global enable; when low, no sample is accepted (config writes still allowed)
s_valid  in  1  sample strobe, one sample per cycle max
s_chan  in  CW=clog2(NCH)  sample channel
s_data  in  DW  sample value
cfg_we  in  1  threshold write strobe
cfg_chan  in  CW  channel to configure
cfg_sel  in  1  0=min threshold, 1=max threshold
cfg_data  in  DW  threshold value
avg_valid  out  1  one-cycle pulse: new average available
avg_chan  out  CW  channel of avg_data
avg_data  out  DW  moving average
avg_primed  out  1  channel has received at least D samples
alert_vec  out  NCH  per-channel debounced alert
alert_any  out  1  OR of alert_vec, registered
drop_err  out  1  sticky: sample with s_chan >= NCH seen

Behaviour:
- Reset, with no other condition taking priority:
  - all outputs 0.
  - ring buffers, sums, pointers, primed bits and debounce counters are 0.
  - min thresholds are 0 and max thresholds are 2^DW-1, so there are no alerts until configured.
- Accept: ena & s_valid & (s_chan < NCH). With s_chan >= NCH the sample is dropped, drop_err is set and stays set until reset, and no other state changes.
- Stage 1, edge after acceptance (T+1):
  - buf[c][ptr[c]] <= s_data.
  - sum[c] <= sum[c] - buf[c][ptr[c]] + s_data. Sum width is DW+AVG_LOG2, unsigned, and can never overflow.
  - ptr[c] increments mod D. primed[c] is set when ptr[c] wraps from D-1 and stays set.
  - avg_valid=1, avg_chan=c, avg_data=new_sum>>AVG_LOG2 (truncating), avg_primed=primed after update.
  - Before priming, the average underestimates because the buffer was zero-filled. This is intended.
- Stage 2, T+2: evaluate avg_data against thresholds registered at T+1.
  - Only primed averages are evaluated; unprimed ones leave the debounce state untouched.
  - out = avg < min | avg > max.
  - in_band = avg >= min+HYST & avg <= max-HYST. Compute in DW+1 bits; if the band is empty, in_band = 0.
  - Alert clear, qualifying = out; alert set, qualifying = in_band. A qualifying average increments cnt[c], saturating at DEB. A non-qualifying average resets cnt[c] to 0.
  - When cnt reaches DEB, alert_vec[c] toggles in that same T+2 update and cnt[c] is cleared.
  - Averages in the window but outside the band hold the alert state and reset cnt while the alert is set.
  - alert_any updates at T+3.
- Latency: sample to avg_valid is 1 cycle; sample to alert_vec is 2 cycles; sample to alert_any is 3 cycles. Throughput is 1 sample/cycle for any channel order, including back-to-back on the same channel; stage 1 is a single-cycle read-modify-write, so no hazard.
- Config:
  - A write takes effect on the next edge. A stage-2 compare in the same cycle uses the old value.
  - cfg_chan >= NCH is ignored.
  - min > max is legal: every primed average is out of range.
- ena low: stage 1 accepts nothing. Samples already in the pipeline complete.
- Reset mid-operation: everything returns to reset values on that edge, and in-flight samples are discarded.

Decomposition:
- Package farm_pkg: localparams for default DW, NCH, AVG_LOG2; CFG_MIN=1'b0 and CFG_MAX=1'b1 select encodings; a clog2 helper.
- Sub-module alert_debounce, one per channel, generated NCH times. Inputs: eval strobe, out, in_band. Outputs: alert bit, counter. Parameter: DEB.
- Ring buffers and sums live in the top level.

Test Plan:
1. Reset, then ch0 receives 100 x4 -> avg_valid pulses with avg_data 25, 50, 75, 100; avg_primed is 0, 0, 0, 1; alert_vec stays 0.
2. ch1 min=100, max=160, then 200 x6 on ch1 -> the three primed averages of 200 (samples 4, 5, 6) set alert_vec[1] 2 cycles after sample 6; alert_any follows 1 cycle later.
3. Alert set on ch1, then 150 x6 -> averages 187, 175, 162, 150, 150, 150; alert_vec[1] clears 2 cycles after sample 6. Variant with 158 x8 instead -> the alert stays set (158 > 156 = max-HYST).
4. Interleave ch0..ch3 each cycle, with a same-channel back-to-back pair (ch2: 40 then 80 after priming at 0) -> ch2 averages 10, then 30; no lost updates.
5. NCH=3, sample with s_chan=3 -> no avg_valid, drop_err=1 and stays 1; a subsequent ch0 sample is processed normally.
6. Reset asserted between acceptance and T+2 of an out-of-range sample -> no avg_valid after reset, no alert, thresholds back to 0 and 255.
